traffic_light_sequencer: RTL and testbench

//  Main traffic-light FSM. Selects the interval (interval_code) read from the time_parameter

---
 rtl/traffic_light_sequencer.sv | 151 +++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// Main traffic-light FSM: times each phase from the time_parameter value with a 1 Hz down-counter.
// Optional macro SENSOR_EXTEND_EN enables the one-shot main-green extension on side-street demand.
module traffic_light_sequencer #(
  parameter logic [1:0] CODE_BASE = 2'b00,
  parameter logic [1:0] CODE_EXT  = 2'b01,
  parameter logic [1:0] CODE_YEL  = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_hz_enable,
  input  logic       prog_sync,
  input  logic       sensor_sync,
  input  logic       walk_request_sync,
  input  logic [3:0] value,
  output logic [1:0] interval_code,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic       walk_reset
);

  typedef enum logic [2:0] {
    S_MG     = 3'd0,
`ifdef SENSOR_EXTEND_EN
    S_MG_EXT = 3'd1,
`endif
    S_MY     = 3'd2,
    S_WALK   = 3'd3,
    S_SG     = 3'd4,
    S_SY     = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t     state_q, state_d, state_nxt;
  logic [1:0] code_q, code_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_q, load_d;
  logic       walk_pend_q, walk_pend_d;
  logic       walk_reset_q, walk_reset_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;

`ifndef SENSOR_EXTEND_EN
  logic unused_sensor;
  assign unused_sensor = sensor_sync;
`endif

  function automatic logic [1:0] code_of(input state_t s);
    case (s)
`ifdef SENSOR_EXTEND_EN
      S_MG_EXT: code_of = CODE_EXT;
`endif
      S_WALK:   code_of = CODE_EXT;
      S_MY,
      S_SY:     code_of = CODE_YEL;
      default:  code_of = CODE_BASE;
    endcase
  endfunction

  // Returns {main, side, walk}
  function automatic logic [6:0] lamps_of(input state_t s);
    case (s)
      S_MY:    lamps_of = {LAMP_Y, LAMP_R, 1'b0};
      S_WALK:  lamps_of = {LAMP_R, LAMP_R, 1'b1};
      S_SG:    lamps_of = {LAMP_R, LAMP_G, 1'b0};
      S_SY:    lamps_of = {LAMP_R, LAMP_Y, 1'b0};
      default: lamps_of = {LAMP_G, LAMP_R, 1'b0};
    endcase
  endfunction

  always_comb begin
    state_nxt = S_MG;
    case (state_q)
`ifdef SENSOR_EXTEND_EN
      S_MG:     state_nxt = sensor_sync ? S_MG_EXT : S_MY;
      S_MG_EXT: state_nxt = S_MY;
`else
      S_MG:     state_nxt = S_MY;
`endif
      S_MY:     state_nxt = walk_pend_q ? S_WALK : S_SG;
      S_WALK:   state_nxt = S_SG;
      S_SG:     state_nxt = S_SY;
      S_SY:     state_nxt = S_MG;
      default:  state_nxt = S_MG;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_d       = load_q;
    walk_reset_d = 1'b0;
    walk_pend_d  = walk_pend_q | walk_request_sync;
    if (prog_sync) begin
      state_d = S_MG;
      load_d  = 1'b1;
    end else if (load_q) begin
      // A zero interval still needs one tick so the phase is visible
      cnt_d  = (value == 4'd0) ? 4'd1 : value;
      load_d = 1'b0;
    end else if (one_hz_enable) begin
      if (cnt_q > 4'd1) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = state_nxt;
        load_d  = 1'b1;
        if (state_nxt == S_WALK) begin
          walk_pend_d  = 1'b0;
          walk_reset_d = 1'b1;
        end
      end
    end
    code_d                   = code_of(state_d);
    {main_d, side_d, walk_d} = lamps_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_MG;
      code_q       <= 2'b00;
      cnt_q        <= 4'd0;
      load_q       <= 1'b1;
      walk_pend_q  <= 1'b0;
      walk_reset_q <= 1'b0;
      main_q       <= LAMP_G;
      side_q       <= LAMP_R;
      walk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      walk_pend_q  <= walk_pend_d;
      walk_reset_q <= walk_reset_d;
      main_q       <= main_d;
      side_q       <= side_d;
      walk_q       <= walk_d;
    end
  end

  assign interval_code = code_q;
  assign main_light    = main_q;
  assign side_light    = side_q;
  assign walk_light    = walk_q;
  assign walk_reset    = walk_reset_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: a phase monitor records lamps, code, ticks and
// walk_reset pulses per phase; recorded phases are compared against hand-written tables.
module tb_traffic_light_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_hz_enable = 1'b0;
  logic       prog_sync = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       walk_request_sync = 1'b0;
  logic [3:0] value;
  logic [1:0] interval_code;
  logic [2:0] main_light, side_light;
  logic       walk_light, walk_reset;
  logic       zero_yel = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic [1:0] code;
    int         ticks;
    int         wr;
  } phase_t;

  phase_t ph_q[$];
  phase_t exp_q[$];
  phase_t cur;
  logic   have = 1'b0;
  logic   in_rst = 1'b1;

  traffic_light_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .one_hz_enable     (one_hz_enable),
    .prog_sync         (prog_sync),
    .sensor_sync       (sensor_sync),
    .walk_request_sync (walk_request_sync),
    .value             (value),
    .interval_code     (interval_code),
    .main_light        (main_light),
    .side_light        (side_light),
    .walk_light        (walk_light),
    .walk_reset        (walk_reset)
  );

  initial forever #5 clk = ~clk;

  // time_parameter model
  always_comb begin
    case (interval_code)
      2'b00:   value = 4'd6;
      2'b01:   value = 4'd3;
      2'b10:   value = zero_yel ? 4'd0 : 4'd2;
      default: value = 4'd0;
    endcase
  end

  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      one_hz_enable = (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic phase_t ph(input logic [2:0] m, input logic [2:0] s, input logic w,
                                input logic [1:0] c, input int t, input int r);
    phase_t p;
    p.main = m; p.side = s; p.walk = w; p.code = c; p.ticks = t; p.wr = r;
    return p;
  endfunction

  // Phase monitor: the first cycle of a new phase is its LOAD cycle, so its tick is not counted
  always @(negedge clk) begin
    if (reset) begin
      in_rst = 1'b1;
      have   = 1'b0;
    end else begin
      check("lamp_safety",
            {$onehot(main_light), $onehot(side_light), !(main_light[0] && side_light[0])},
            3'b111);
      if (in_rst || !have || {main_light, side_light, walk_light, interval_code} !=
                             {cur.main, cur.side, cur.walk, cur.code}) begin
        if (have) ph_q.push_back(cur);
        in_rst = 1'b0;
        have   = 1'b1;
        cur    = ph(main_light, side_light, walk_light, interval_code, 0, int'(walk_reset));
      end else begin
        if (one_hz_enable) cur.ticks++;
        cur.wr += int'(walk_reset);
      end
    end
  end

  task automatic compare_phases(input string tag);
    int n = exp_q.size();
    int k = 0;
    while (ph_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (ph_q.size() < n) check({tag, "_timeout"}, ph_q.size(), n);
    for (int i = 0; i < n && ph_q.size() > 0; i++) begin
      phase_t a = ph_q.pop_front();
      check($sformatf("%s_ph%0d_lamps_code", tag, i),
            {a.main, a.side, a.walk, a.code},
            {exp_q[i].main, exp_q[i].side, exp_q[i].walk, exp_q[i].code});
      check($sformatf("%s_ph%0d_ticks", tag, i), a.ticks, exp_q[i].ticks);
      check($sformatf("%s_ph%0d_walk_reset", tag, i), a.wr, exp_q[i].wr);
    end
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {interval_code, main_light, side_light, walk_light, walk_reset},
          {2'b00, 3'b001, 3'b100, 1'b0, 1'b0});
    reset = 1'b0;
    ph_q.delete();
  endtask

  task automatic wait_until_lamps(input string tag, input logic [6:0] want);
    int k = 0;
    while ({main_light, side_light, walk_light} != want && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_reached"}, {main_light, side_light, walk_light}, want);
  endtask

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  initial begin
    // 1: free-running cycle
    apply_reset();
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0), ph(Y, R, 0, 2'b10, 2, 0),
              ph(R, G, 0, 2'b00, 6, 0), ph(R, Y, 0, 2'b10, 2, 0)};
    compare_phases("cycle");

    // 2: walk request served once
    apply_reset();
    repeat (3) @(posedge clk);
    #1 walk_request_sync = 1'b1;
    @(posedge clk); #1 walk_request_sync = 1'b0;
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0), ph(Y, R, 0, 2'b10, 2, 0),
              ph(R, R, 1, 2'b01, 3, 1), ph(R, G, 0, 2'b00, 6, 0),
              ph(R, Y, 0, 2'b10, 2, 0), ph(G, R, 0, 2'b00, 6, 0),
              ph(Y, R, 0, 2'b10, 2, 0)};
    compare_phases("walk");

    // 3: side-street sensor at main-green expiry
    apply_reset();
    sensor_sync = 1'b1;
`ifdef SENSOR_EXTEND_EN
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0), ph(G, R, 0, 2'b01, 3, 0),
              ph(Y, R, 0, 2'b10, 2, 0)};
`else
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0), ph(Y, R, 0, 2'b10, 2, 0),
              ph(R, G, 0, 2'b00, 6, 0)};
`endif
    compare_phases("sensor");
    sensor_sync = 1'b0;

    // 4: reprogram strobe mid side-green
    apply_reset();
    wait_until_lamps("prog_sg", {R, G, 1'b0});
    repeat (5) @(posedge clk);
    #1 prog_sync = 1'b1;
    @(posedge clk); #1 prog_sync = 1'b0;
    check("prog_outputs", {interval_code, main_light, side_light, walk_light},
          {2'b00, G, R, 1'b0});
    @(negedge clk); #1 ph_q.delete();
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0)};
    compare_phases("prog");

    // 5: zero-length yellow interval runs one tick
    zero_yel = 1'b1;
    apply_reset();
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0), ph(Y, R, 0, 2'b10, 1, 0),
              ph(R, G, 0, 2'b00, 6, 0), ph(R, Y, 0, 2'b10, 1, 0)};
    compare_phases("zero");
    zero_yel = 1'b0;

    // 6: reset during WALK with a fresh request pending
    apply_reset();
    #0 walk_request_sync = 1'b1;
    @(posedge clk); #1 walk_request_sync = 1'b0;
    wait_until_lamps("rstwalk_walk", {R, R, 1'b1});
    repeat (2) @(posedge clk);
    #1 walk_request_sync = 1'b1;
    @(posedge clk); #1 walk_request_sync = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstwalk_outputs", {interval_code, main_light, side_light, walk_light, walk_reset},
          {2'b00, G, R, 1'b0, 1'b0});
    reset = 1'b0;
    ph_q.delete();
    exp_q = '{ph(G, R, 0, 2'b00, 6, 0), ph(Y, R, 0, 2'b10, 2, 0),
              ph(R, G, 0, 2'b00, 6, 0)};
    compare_phases("rstwalk");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
